power_spectrum_streamer: RTL
============================

Name: power_spectrum_streamer

Overview:
- Producer side of the periodogram stream that feeds the mel filterbank's data_in/data_valid input.
- Accepts complex FFT bins (Q15 re/im) and computes power |X|^2 = re^2 + im^2 in Q30.
- Buffers one frame of NUM_BINS powers, then replays the frame as a contiguous stream.
- Sits between the FFT and the mel filterbank in the MFCC front end.

Parameters:
- NUM_BINS, 23: bins per frame; must equal the filterbank's FILTER_SIZE.
- IN_W, 16: width of fft_re/fft_im, signed Q15.
- OUT_W, 32: width of pow_out, signed Q30.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fft_re  in  IN_W  real part, signed Q15
- fft_im  in  IN_W  imaginary part, signed Q15
- fft_valid  in  1  input bin valid
- fft_last  in  1  marks final bin of the FFT frame
- fft_ready  out  1  block accepts an input bin this cycle
- pow_out  out  OUT_W  power, signed Q30; drives filterbank data_in
- pow_valid  out  1  drives filterbank data_valid
- pow_last  out  1  high with the final bin of an output frame
- out_ready  in  1  downstream accept; tie to 1 for the filterbank
- err_short  out  1  one-cycle pulse when a frame ends early via fft_last

Behaviour:
- Reset values: fft_ready=0, pow_out=0, pow_valid=0, pow_last=0, err_short=0. State=CAPTURE, counters=0. Buffer contents don't care.
- fft_ready goes high on the first cycle after reset deasserts.
- FSM states:
  - CAPTURE: fft_ready=1. Transfer occurs when fft_valid && fft_ready.
  - DRAIN: fft_ready=0. Waits for the in-flight pipeline writes to land.
  - SEND: fft_ready=0. Replays buffer bins 0..NUM_BINS-1.
- Datapath: 2-stage pipeline.
  - Stage 1 registers re*re and im*im (2*IN_W signed products).
  - Stage 2 forms the unsigned 2*IN_W+1 sum and saturates to 0x7FFFFFFF if it is >= 2^31, then writes buffer[wr_idx].
- CAPTURE -> DRAIN occurs on a transfer where wr_idx==NUM_BINS-1, or where fft_last=1.
  - fft_last asserted with wr_idx<NUM_BINS-1: remaining bins are zero-filled, one per cycle in DRAIN; err_short pulses for 1 cycle on the fft_last transfer.
  - fft_last on bin NUM_BINS-1: normal close, no error.
  - fft_last absent on bin NUM_BINS-1: frame still closes; the next bin is stalled by fft_ready=0.
- DRAIN -> SEND once the pipeline is empty and zero-fill is complete.
- Latency: first pow_valid occurs exactly 3 cycles after the accepting edge of the final bin (no zero-fill case).
- SEND handshake:
  - pow_out/pow_valid are registered.
  - Bin advances on pow_valid && out_ready.
  - While out_ready=0, pow_out holds stable.
  - With out_ready tied high, NUM_BINS consecutive valid cycles.
- pow_last=1 with bin NUM_BINS-1. After its acceptance: pow_valid=0 next cycle and state returns to CAPTURE with fft_ready=1 the same next cycle.
- fft_valid is ignored when fft_ready=0. The upstream FFT must hold data (valid/ready semantics).
- rst mid-frame aborts capture or send immediately. No partial frame is emitted afterwards.
- Arithmetic worst case: re=im=-32768 gives 2^31, which saturates to 0x7FFFFFFF. All outputs are non-negative.

Optional Feature:
- Macro POWER_SHIFT_EN.
- Defined: adds input port pow_shift[4:0], sampled at CAPTURE entry and held for the frame. Stage 2 applies a logical right shift by pow_shift to the sum before saturation. This provides headroom for the filterbank's 48-bit accumulator.
- Undefined: port absent, shift fixed at 0; behaviour otherwise identical.

Decomposition:
- Shared package mfcc_pkg, containing:
  - Q-format constants: Q_IN=15, Q_POW=30.
  - NUM_BINS default.
  - POW_SAT=32'h7FFFFFFF.
  - FSM state enum {CAPTURE, DRAIN, SEND}.
- One natural sub-module: cplx_power_sq, the 2-stage square-sum-saturate pipeline with valid passthrough.
- Buffer and FSM stay in the top module.

Test Plan:
- Full frame: 23 bins with re=0x4000, im=0 -> 23 outputs of 0x10000000 (0.25 Q30). pow_last on bin 22. First pow_valid 3 cycles after last accept.
- Saturation: bin re=im=0x8000 -> 0x7FFFFFFF. Bin re=0x7FFF, im=0x7FFF -> 0x7FFE0002.
- Short frame: fft_last on bin 9 -> err_short 1 pulse; output bins 10..22 = 0; full 23-bin output frame.
- Backpressure: out_ready toggled 1010... during SEND -> every bin appears exactly once, in order, with pow_out stable while stalled. fft_ready=0 throughout SEND.
- Reset mid-SEND: rst asserted at output bin 5 -> next cycle pow_valid=0, pow_last=0. After release, a new 23-bin input frame produces only the new data.
- POWER_SHIFT_EN with pow_shift=4: re=im=0x8000 -> 0x08000000, no saturation.

Source files
------------

// File: rtl/mfcc_pkg.sv
// mfcc_pkg: shared Q-format constants, saturation limit and streamer FSM states for the MFCC front end.
package mfcc_pkg;
    localparam int Q_IN = 15;
    localparam int Q_POW = 30;
    localparam int NUM_BINS = 23;
    localparam logic [31:0] POW_SAT = 32'h7FFFFFFF;
    typedef enum logic [1:0] {CAPTURE, DRAIN, SEND} state_t;
endpackage

// File: rtl/cplx_power_sq.sv
// cplx_power_sq: two-stage re^2+im^2 pipeline with logical right shift and Q30 saturation.
// Stage 1 registers the squares; stage 2 is combinational and lands in the caller's buffer.
module cplx_power_sq
    import mfcc_pkg::*;
#(
    parameter int IN_W = 16,
    parameter int OUT_W = 32,
    parameter int IDX_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  re,
    input  logic signed [IN_W-1:0]  im,
    input  logic                    in_valid,
    input  logic [IDX_W-1:0]        in_idx,
    input  logic [4:0]              shift,
    output logic [OUT_W-1:0]        pw,
    output logic                    pw_valid,
    output logic [IDX_W-1:0]        pw_idx
);
    localparam int SW = 2 * IN_W + 1;
    logic signed [2*IN_W-1:0] sq_re, sq_im;
    logic [SW-1:0] sum, sh;
    always_ff @(posedge clk) begin
        pw_valid <= rst ? 1'b0 : in_valid;
        sq_re <= re * re;
        sq_im <= im * im;
        pw_idx <= in_idx;
    end
    // Squares are never negative, so the sum is taken unsigned with one guard bit.
    assign sum = {1'b0, sq_re} + {1'b0, sq_im};
    assign sh = sum >> shift;
    assign pw = sh > SW'(POW_SAT) ? OUT_W'(POW_SAT) : OUT_W'(sh);
endmodule

// File: rtl/power_spectrum_streamer.sv
// power_spectrum_streamer: captures one frame of FFT bin powers and replays it as a contiguous stream.
// Build option POWER_SHIFT_EN adds pow_shift, a per-frame right shift applied before saturation.
module power_spectrum_streamer
    import mfcc_pkg::*;
#(
    parameter int NUM_BINS = mfcc_pkg::NUM_BINS,
    parameter int IN_W = 16,
    parameter int OUT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  fft_re,
    input  logic signed [IN_W-1:0]  fft_im,
    input  logic                    fft_valid,
    input  logic                    fft_last,
    output logic                    fft_ready,
`ifdef POWER_SHIFT_EN
    input  logic [4:0]              pow_shift,
`endif
    output logic [OUT_W-1:0]        pow_out,
    output logic                    pow_valid,
    output logic                    pow_last,
    input  logic                    out_ready,
    output logic                    err_short
);
    localparam int IDX_W = $clog2(NUM_BINS + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BINS - 1);
    localparam logic [IDX_W-1:0] FULL = IDX_W'(NUM_BINS);
    state_t state, next;
    logic [IDX_W-1:0] wr_idx, rd_idx, pw_idx;
    logic [OUT_W-1:0] mem [NUM_BINS];
    logic [OUT_W-1:0] pw;
    logic [4:0] shift;
    logic xfer, fill, in_valid, pw_valid;
    assign fft_ready = state == CAPTURE && !rst;
    assign xfer = fft_valid && fft_ready;
    assign fill = state == DRAIN && wr_idx != FULL;
    assign in_valid = xfer || fill;
    always_comb begin
        next = state;
        next = state == CAPTURE ? (xfer && (fft_last || wr_idx == LAST) ? DRAIN : CAPTURE)
             : state == DRAIN ? (wr_idx == FULL && !pw_valid ? SEND : DRAIN)
             : (pow_valid && out_ready && pow_last ? CAPTURE : SEND);
    end
    always_ff @(posedge clk) begin
        state <= rst ? CAPTURE : next;
        wr_idx <= rst || state == SEND ? '0 : in_valid ? wr_idx + 1'b1 : wr_idx;
        err_short <= !rst && xfer && fft_last && wr_idx != LAST;
    end
`ifdef POWER_SHIFT_EN
    always_ff @(posedge clk) begin
        if (rst || (state == SEND && next == CAPTURE)) shift <= pow_shift;
    end
`else
    assign shift = '0;
`endif
    // Zero-fill after an early fft_last reuses the pipeline so the buffer keeps a single write port.
    cplx_power_sq #(.IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) u_sq (
        .clk(clk),
        .rst(rst),
        .re(fill ? '0 : fft_re),
        .im(fill ? '0 : fft_im),
        .in_valid(in_valid),
        .in_idx(wr_idx),
        .shift(shift),
        .pw(pw),
        .pw_valid(pw_valid),
        .pw_idx(pw_idx)
    );
    always_ff @(posedge clk) begin
        if (pw_valid) mem[pw_idx] <= pw;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pow_out <= '0;
            pow_valid <= 1'b0;
            pow_last <= 1'b0;
            rd_idx <= '0;
        end else if (state != SEND) begin
            pow_valid <= 1'b0;
            pow_last <= 1'b0;
            rd_idx <= '0;
        end else if (!pow_valid || out_ready) begin
            pow_valid <= rd_idx != FULL;
            pow_last <= rd_idx == LAST;
            if (rd_idx != FULL) begin
                pow_out <= mem[rd_idx];
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end
endmodule
